// File: rtl/fetch_stage.sv
// Instruction fetch stage: keeps one request in flight to instruction memory and
// pushes {pc, inst} into the instruction queue, with a hold slot for backpressure.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int          IQ_WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic [31:0]         imem_addr,
    output logic [3:0]          imem_rmask,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_resp,
    input  logic                iq_full,
    output logic                iq_enqueue,
    output logic [IQ_WIDTH-1:0] iq_wdata
);

    typedef enum logic [1:0] {
        S_ISSUE   = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [3:0]  rmask_s;
    logic        enq_s;
    logic [31:0] inst_s;
    logic [31:0] target_s;

    assign target_s  = {redirect_pc[31:2], 2'b00};
    assign imem_addr = pc_q;

    // State, pc and hold register updates
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ISSUE;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic and raw request/enqueue decisions
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        rmask_s = 4'b0000;
        enq_s   = 1'b0;
        inst_s  = 32'd0;
        case (state_q)
            S_ISSUE: begin
                if (redirect) begin
                    pc_d = target_s;
                end else begin
                    rmask_s = 4'b1111;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // A pending response must still be drained before the next request.
                    pc_d    = target_s;
                    state_d = imem_resp ? S_ISSUE : S_DISCARD;
                end else if (imem_resp) begin
                    if (iq_full) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        enq_s   = 1'b1;
                        inst_s  = imem_rdata;
                        pc_d    = pc_q + 32'd4;
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target_s;
                    state_d = S_ISSUE;
                end else if (!iq_full) begin
                    enq_s   = 1'b1;
                    inst_s  = hold_q;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_resp) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_DISCARD;
                end
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase
    end

    // Output gating: reset silences requests and enqueues, idle payload reads zero
    always_comb begin
        imem_rmask = 4'b0000;
        iq_enqueue = 1'b0;
        iq_wdata   = {IQ_WIDTH{1'b0}};
        if (rst) begin
            imem_rmask = 4'b0000;
            iq_enqueue = 1'b0;
        end else begin
            imem_rmask = rmask_s;
            iq_enqueue = enq_s;
            if (enq_s) begin
                iq_wdata = IQ_WIDTH'({pc_q, inst_s});
            end else begin
                iq_wdata = {IQ_WIDTH{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected requests and enqueues are queued per
// scenario and matched, with cycle stamps, against what the DUT produces.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h1eceb000;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        iq_full = 1'b0;
    logic        iq_enqueue;
    logic [63:0] iq_wdata;

    logic        mem_resp = 1'b0;
    logic [31:0] mem_data = 32'd0;
    logic        force_resp = 1'b0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'd0;
    int          lat = 1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        req_q[$];
    exp_t        enq_q[$];

    assign imem_resp  = mem_resp | force_resp;
    assign imem_rdata = force_resp ? 32'hdeadbeef : mem_data;

    fetch_stage #(.RESET_PC(RPC), .IQ_WIDTH(64)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata),
        .imem_resp(imem_resp), .iq_full(iq_full), .iq_enqueue(iq_enqueue),
        .iq_wdata(iq_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hc0def00d;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic exp_req(input logic [31:0] a, input int c);
        exp_t e;
        e.addr = a;
        e.cyc  = c;
        req_q.push_back(e);
    endtask

    task automatic exp_enq(input logic [31:0] a, input int c);
        exp_t e;
        e.addr = a;
        e.cyc  = c;
        enq_q.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        if (rst) begin
            check_val("rst_rmask", 64'(imem_rmask), 64'd0);
            check_val("rst_enq", 64'(iq_enqueue), 64'd0);
            check_val("rst_wdata", iq_wdata, 64'd0);
            pend = 1'b0;
        end else begin
            if (!iq_enqueue) check_val("idle_wdata", iq_wdata, 64'd0);
            if (imem_rmask != 4'b0000) begin
                check_val("rmask", 64'(imem_rmask), 64'hf);
                if (req_q.size() == 0) begin
                    check_val("req_extra", 64'(req_q.size()), 64'd1);
                end else begin
                    e = req_q.pop_front();
                    check_val("req_addr", 64'(imem_addr), 64'(e.addr));
                    check_val("req_cyc", 64'(cyc), 64'(e.cyc));
                end
                pend      = 1'b1;
                pend_cnt  = lat;
                pend_addr = imem_addr;
            end
            if (iq_enqueue) begin
                check_val("enq_guard", 64'({redirect, iq_full}), 64'd0);
                if (enq_q.size() == 0) begin
                    check_val("enq_extra", 64'(enq_q.size()), 64'd1);
                end else begin
                    e = enq_q.pop_front();
                    check_val("enq_data", iq_wdata, {e.addr, mdata(e.addr)});
                    check_val("enq_cyc", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        cyc++;
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        mem_data = 32'd0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_resp = 1'b1;
                mem_data = mdata(pend_addr);
                pend     = 1'b0;
            end
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        steps(n);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic finish_scn(input string tag);
        check_val({tag, "_req_left"}, 64'(req_q.size()), 64'd0);
        check_val({tag, "_enq_left"}, 64'(enq_q.size()), 64'd0);
        req_q.delete();
        enq_q.delete();
    endtask

    initial begin
        // Straight-line fetch, one instruction per two cycles, spurious resp in ISSUE
        lat = 1;
        do_reset(3);
        exp_req(RPC, 0);          exp_enq(RPC, 1);
        exp_req(RPC + 32'd4, 2);  exp_enq(RPC + 32'd4, 3);
        exp_req(RPC + 32'd8, 4);  exp_enq(RPC + 32'd8, 5);
        steps(2);
        force_resp = 1'b1;
        step();
        force_resp = 1'b0;
        steps(3);
        finish_scn("stream");

        // Queue full on second response, held three cycles
        do_reset(2);
        exp_req(RPC, 0);          exp_enq(RPC, 1);
        exp_req(RPC + 32'd4, 2);  exp_enq(RPC + 32'd4, 6);
        exp_req(RPC + 32'd8, 7);  exp_enq(RPC + 32'd8, 8);
        steps(3);
        iq_full = 1'b1;
        step();
        force_resp = 1'b1;
        step();
        force_resp = 1'b0;
        step();
        iq_full = 1'b0;
        steps(3);
        finish_scn("hold");

        // Redirect in WAIT, stale response two cycles later
        lat = 3;
        do_reset(2);
        exp_req(RPC, 0);
        exp_req(32'h00001000, 4); exp_enq(32'h00001000, 7);
        exp_req(32'h00001004, 8);
        step();
        redirect = 1'b1;
        redirect_pc = 32'h00001002;
        step();
        redirect = 1'b0;
        steps(7);
        finish_scn("discard");

        // Second redirect while discarding retargets again
        do_reset(2);
        exp_req(RPC, 0);
        exp_req(32'h00002000, 4);
        step();
        redirect = 1'b1;
        redirect_pc = 32'h00001002;
        step();
        redirect_pc = 32'h00002000;
        step();
        redirect = 1'b0;
        steps(2);
        finish_scn("discard2");

        // Redirect coincident with response
        lat = 1;
        do_reset(2);
        exp_req(RPC, 0);
        exp_req(32'h00003000, 2); exp_enq(32'h00003000, 3);
        step();
        redirect = 1'b1;
        redirect_pc = 32'h00003000;
        step();
        redirect = 1'b0;
        steps(2);
        finish_scn("redir_resp");

        // Redirect during HOLD, then pc wrap from fffffffc to 0
        do_reset(2);
        exp_req(RPC, 0);
        exp_req(32'hfffffffc, 3); exp_enq(32'hfffffffc, 4);
        exp_req(32'h00000000, 5); exp_enq(32'h00000000, 6);
        step();
        iq_full = 1'b1;
        step();
        redirect = 1'b1;
        redirect_pc = 32'hffffffff;
        step();
        redirect = 1'b0;
        iq_full = 1'b0;
        steps(4);
        finish_scn("hold_redir");

        // Redirect held through reset and into the first ISSUE cycle
        redirect = 1'b1;
        redirect_pc = 32'h00004000;
        do_reset(2);
        exp_req(32'h00004000, 1); exp_enq(32'h00004000, 2);
        step();
        redirect = 1'b0;
        steps(2);
        finish_scn("issue_redir");

        // Reset with redirect while a request is outstanding
        lat = 2;
        do_reset(2);
        exp_req(RPC, 0);
        step();
        redirect = 1'b1;
        redirect_pc = 32'h00005000;
        do_reset(2);
        redirect = 1'b0;
        exp_req(RPC, 0);          exp_enq(RPC, 2);
        steps(3);
        finish_scn("rst_wait");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
